set_assoc_cache: RTL and testbench
==================================

// Module: set_assoc_cache
// PURPOSE
//  Read-only, parametrised N-way set-associative cache between processor fetch bus and DRAM bus.
//  Successor to the 32-set direct-mapped block: configurable ways/sets/line size, real hit path,
//  per-set round-robin replacement, critical-word-first response with wrap-around.
//  Sits between core p_bus_* and memory m_bus_* (Sysbus handshake).
// PARAMETERS
//  BUS_DATA_WIDTH  64   data/address width of both buses (fixed 64; other values unsupported)
//  BUS_TAG_WIDTH   13   request tag width
//  WAYS            2    associativity, power of 2, 1..8
//  SETS            32   sets, power of 2, 2..256
//  LINE_WORDS      8    64-bit words per line, power of 2, 2..16
// PORTS
//  clk            in   1    clock, all logic on posedge
//  reset          in   1    synchronous, active-low reset (0 = reset)
//  p_bus_reqcyc   in   1    processor read request valid
//  p_bus_reqack   out  1    one-cycle accept pulse
//  p_bus_req      in   64   byte address
//  p_bus_reqtag   in   13   request tag
//  p_bus_respcyc  out  1    response beat valid
//  p_bus_respack  in   1    processor accepted current beat
//  p_bus_resp     out  64   response data
//  p_bus_resptag  out  13   tag of request being answered
//  m_bus_reqcyc   out  1    line fill request valid
//  m_bus_reqack   in   1    memory accepted request
//  m_bus_req      out  64   line-aligned fill address
//  m_bus_reqtag   out  13   = captured p_bus_reqtag
//  m_bus_respcyc  in   1    fill beat valid
//  m_bus_respack  out  1    fill beat accepted (same cycle as respcyc)
//  m_bus_resp     in   64   fill data, beats in order word 0..LINE_WORDS-1
//  m_bus_resptag  in   13   fill tag
// BEHAVIOUR
//  Address split: OFF=log2(LINE_WORDS*8), IDX=log2(SETS), TAG=64-IDX-OFF; word ptr = addr[OFF-1:3].
//  Reset (reset==0 at posedge): state IDLE, all valid bits 0, RR pointers 0; all outputs 0.
//  FSM: IDLE -> ACK -> LOOKUP -> {RESPOND | MEMREQ -> FILL -> RESPOND} -> IDLE.
//   IDLE: capture addr/tag when p_bus_reqcyc=1. Requests while not IDLE get no reqack.
//   ACK: p_bus_reqack=1 for exactly one cycle.
//   LOOKUP: compare all ways; hit -> RESPOND, miss -> MEMREQ. Hit latency: reqcyc@0, ack@1, respcyc@3.
//   MEMREQ: hold m_bus_reqcyc/req/reqtag stable until m_bus_reqack=1, then FILL.
//   FILL: m_bus_respack=m_bus_respcyc; beat with wrong resptag acked and dropped; LINE_WORDS good
//    beats written into victim way; after last beat set valid, write tag, advance RR, go RESPOND.
//   Victim: lowest-index invalid way, else rr_ptr[set]; rr_ptr wraps WAYS-1 -> 0.
//   RESPOND: p_bus_respcyc=1, resp=word[ptr], resptag=captured tag; data held until respack.
//    ptr starts at requested word, increments mod LINE_WORDS (wrap); exactly LINE_WORDS beats,
//    then IDLE. Hit in multiple ways cannot occur (fill never duplicates).
//  reset mid-fill/mid-response: abort immediately, line not validated, outputs 0 next cycle.
// CONFIGURATION
//  SA_CACHE_PERF_CNT_EN defined: adds outputs hit_count[31:0], miss_count[31:0]; +1 per LOOKUP,
//   saturate at 2^32-1, cleared by reset. Undefined: ports and counters absent, behaviour identical.
// STRUCTURE
//  cache_pkg: state enum, derived widths (OFF/IDX/TAG), line/tag-entry typedefs.
//  Sub-module cache_way_array (one per way: valid, tag, data storage; read by index, line write).
//  Top holds FSM, victim select, RR pointers, beat counters.
// TESTING
//  Cold miss 0x1000: one m_bus_req=0x1000, 8 fill beats, 8 resp beats word0..7, reqack once.
//  Re-read 0x1018 (hit): no m_bus_reqcyc, respcyc at cycle 3, beats word3,4..7,0,1,2.
//  WAYS=2,SETS=32,LINE=8: 0x0000,0x0800,0x1000 same set -> 3rd evicts way0; 0x0800 still hits.
//  respack held 0 for 5 cycles on beat 2: resp/resptag stable, no advance; tag 0x1A5 echoed.
//  m_bus_reqack delayed 10 cycles: m_bus_req stable; reset=0 during FILL -> 0x1000 misses after.
//  SA_CACHE_PERF_CNT_EN: miss,hit,hit sequence -> hit_count=2, miss_count=1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative fetch cache.
// Consumed by set_assoc_cache and cache_way_array.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_LOOKUP,
    S_MEMREQ,
    S_FILL,
    S_RESP
  } state_t;

  typedef logic [63:0] word_t;

  localparam int WORD_BYTES = 8;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set valid bit, tag and line storage.
// Async read by set index and word; word writes during fill.
module cache_way_array
  import cache_pkg::*;
#(
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 8,
  parameter int TAGW       = 51,
  localparam int IW = $clog2(SETS),
  localparam int WB = $clog2(LINE_WORDS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IW-1:0]   idx,
  input  logic [WB-1:0]   word,
  input  logic            wr_en,
  input  word_t           wdata,
  input  logic            fin_en,
  input  logic [TAGW-1:0] ftag,
  output logic            valid,
  output logic [TAGW-1:0] tag,
  output word_t           rdata
);

  logic [SETS-1:0] vld_q;
  logic [TAGW-1:0] tag_q  [SETS];
  word_t           data_q [SETS*LINE_WORDS];
  logic [IW+WB-1:0] waddr;

  assign waddr = {idx, word};
  assign valid = vld_q[idx];
  assign tag   = tag_q[idx];
  assign rdata = data_q[waddr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
    end else if (fin_en) begin
      vld_q[idx] <= 1'b1;
    end
  end

  // storage is only trusted once the valid bit is set
  always_ff @(posedge clk) begin
    if (wr_en) data_q[waddr] <= wdata;
    if (fin_en) tag_q[idx] <= ftag;
  end

endmodule

// File: rtl/set_assoc_cache.sv
// Read-only N-way set-associative fetch cache, critical-word-first.
// Define SA_CACHE_PERF_CNT_EN to add hit_count/miss_count outputs.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int WAYS           = 2,
  parameter int SETS           = 32,
  parameter int LINE_WORDS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      p_bus_reqcyc,
  output logic                      p_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] p_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  p_bus_reqtag,
  output logic                      p_bus_respcyc,
  input  logic                      p_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] p_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  p_bus_resptag,
  output logic                      m_bus_reqcyc,
  input  logic                      m_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  input  logic                      m_bus_respcyc,
  output logic                      m_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag
`ifdef SA_CACHE_PERF_CNT_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
`endif
);

  localparam int OFF = $clog2(LINE_WORDS * WORD_BYTES);
  localparam int IW  = $clog2(SETS);
  localparam int WB  = $clog2(LINE_WORDS);
  localparam int TW  = BUS_DATA_WIDTH - IW - OFF;
  localparam int WW  = clog2_min1(WAYS);

  state_t state_q, state_d;

  logic [BUS_DATA_WIDTH-1:3] addr_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic [WB-1:0]             ptr_q;
  logic [WB-1:0]             cnt_q;
  logic [WW-1:0]             way_q;
  logic [WW-1:0]             rr_q [SETS];

  logic [IW-1:0] idx;
  logic [TW-1:0] atag;
  logic [WB-1:0] word_sel;
  logic [WAYS-1:0] vld;
  logic [TW-1:0] wtag [WAYS];
  word_t         wdat [WAYS];

  logic          hit;
  logic [WW-1:0] hit_way;
  logic [WW-1:0] victim;
  logic [WW-1:0] rr_nxt;
  logic          beat_ok;
  logic          fill_fin;
  logic          unused_lsb;

  assign unused_lsb = ^p_bus_req[2:0];
  assign idx        = addr_q[OFF+IW-1:OFF];
  assign atag       = addr_q[BUS_DATA_WIDTH-1:OFF+IW];
  assign word_sel   = (state_q == S_FILL) ? cnt_q : ptr_q;
  assign beat_ok    = (state_q == S_FILL) && m_bus_respcyc
                      && (m_bus_resptag == tag_q);
  assign fill_fin   = beat_ok && (cnt_q == WB'(LINE_WORDS - 1));
  assign rr_nxt     = (rr_q[idx] == WW'(WAYS - 1)) ? '0
                      : rr_q[idx] + 1'b1;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way_array #(
      .SETS      (SETS),
      .LINE_WORDS(LINE_WORDS),
      .TAGW      (TW)
    ) u_way (
      .clk   (clk),
      .reset (reset),
      .idx   (idx),
      .word  (word_sel),
      .wr_en (beat_ok && (way_q == WW'(g))),
      .wdata (m_bus_resp),
      .fin_en(fill_fin && (way_q == WW'(g))),
      .ftag  (atag),
      .valid (vld[g]),
      .tag   (wtag[g]),
      .rdata (wdat[g])
    );
  end

  // victim: lowest invalid way, otherwise the set's round-robin pointer
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = rr_q[idx];
    for (int w = 0; w < WAYS; w++) begin
      if (vld[w] && (wtag[w] == atag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vld[w]) victim = WW'(w);
    end
  end

  always_comb begin
    state_d       = state_q;
    p_bus_reqack  = 1'b0;
    p_bus_respcyc = 1'b0;
    p_bus_resp    = '0;
    p_bus_resptag = '0;
    m_bus_reqcyc  = 1'b0;
    m_bus_req     = '0;
    m_bus_reqtag  = '0;
    m_bus_respack = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (p_bus_reqcyc) state_d = S_ACK;
      end
      S_ACK: begin
        p_bus_reqack = 1'b1;
        state_d      = S_LOOKUP;
      end
      S_LOOKUP: begin
        state_d = hit ? S_RESP : S_MEMREQ;
      end
      S_MEMREQ: begin
        m_bus_reqcyc = 1'b1;
        m_bus_req    = {addr_q[BUS_DATA_WIDTH-1:OFF], {OFF{1'b0}}};
        m_bus_reqtag = tag_q;
        if (m_bus_reqack) state_d = S_FILL;
      end
      S_FILL: begin
        m_bus_respack = m_bus_respcyc;
        if (fill_fin) state_d = S_RESP;
      end
      S_RESP: begin
        p_bus_respcyc = 1'b1;
        p_bus_resp    = wdat[way_q];
        p_bus_resptag = tag_q;
        if (p_bus_respack && (cnt_q == WB'(LINE_WORDS - 1)))
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // cnt_q counts fill beats then response beats; it wraps to 0 between them
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      tag_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      way_q   <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && p_bus_reqcyc) begin
        addr_q <= p_bus_req[BUS_DATA_WIDTH-1:3];
        tag_q  <= p_bus_reqtag;
      end
      if (state_q == S_LOOKUP) begin
        way_q <= hit ? hit_way : victim;
        cnt_q <= '0;
        ptr_q <= addr_q[OFF-1:3];
      end
      if (beat_ok) cnt_q <= cnt_q + 1'b1;
      if (fill_fin) rr_q[idx] <= rr_nxt;
      if ((state_q == S_RESP) && p_bus_respack) begin
        ptr_q <= ptr_q + 1'b1;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef SA_CACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit && (hit_count != '1))
        hit_count <= hit_count + 1'b1;
      if (!hit && (miss_count != '1))
        miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: directed cases then random reads
// against an array-based model of sets, ways and round-robin.
module tb_set_assoc_cache;

  localparam int WAYS = 2;
  localparam int SETS = 32;
  localparam int LW   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_bus_reqcyc, p_bus_reqack;
  logic [63:0] p_bus_req;
  logic [12:0] p_bus_reqtag;
  logic        p_bus_respcyc, p_bus_respack;
  logic [63:0] p_bus_resp;
  logic [12:0] p_bus_resptag;
  logic        m_bus_reqcyc, m_bus_reqack;
  logic [63:0] m_bus_req;
  logic [12:0] m_bus_reqtag;
  logic        m_bus_respcyc, m_bus_respack;
  logic [63:0] m_bus_resp;
  logic [12:0] m_bus_resptag;
`ifdef SA_CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  set_assoc_cache #(
    .BUS_DATA_WIDTH(64),
    .BUS_TAG_WIDTH (13),
    .WAYS          (WAYS),
    .SETS          (SETS),
    .LINE_WORDS    (LW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .p_bus_reqcyc (p_bus_reqcyc),
    .p_bus_reqack (p_bus_reqack),
    .p_bus_req    (p_bus_req),
    .p_bus_reqtag (p_bus_reqtag),
    .p_bus_respcyc(p_bus_respcyc),
    .p_bus_respack(p_bus_respack),
    .p_bus_resp   (p_bus_resp),
    .p_bus_resptag(p_bus_resptag),
    .m_bus_reqcyc (m_bus_reqcyc),
    .m_bus_reqack (m_bus_reqack),
    .m_bus_req    (m_bus_req),
    .m_bus_reqtag (m_bus_reqtag),
    .m_bus_respcyc(m_bus_respcyc),
    .m_bus_respack(m_bus_respack),
    .m_bus_resp   (m_bus_resp),
    .m_bus_resptag(m_bus_resptag)
`ifdef SA_CACHE_PERF_CNT_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  int total = 0;
  int bad   = 0;
  int mhits = 0;
  int mmiss = 0;

  logic [52:0] mtag [SETS][WAYS];
  bit          mval [SETS][WAYS];
  int          mrr  [SETS];

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < WAYS; w++) mval[s][w] = 1'b0;
    end
    mhits = 0;
    mmiss = 0;
  endfunction

  // returns 1 on hit; on miss installs the line as the cache should
  function automatic bit model_access(input logic [63:0] a);
    int s;
    int v;
    logic [52:0] tg;
    s  = int'(a[10:6]);
    tg = a[63:11];
    for (int w = 0; w < WAYS; w++)
      if (mval[s][w] && mtag[s][w] == tg) return 1'b1;
    v = -1;
    for (int w = 0; w < WAYS; w++)
      if (!mval[s][w] && v < 0) v = w;
    if (v < 0) v = mrr[s];
    mrr[s] = (mrr[s] + 1) % WAYS;
    mval[s][v] = 1'b1;
    mtag[s][v] = tg;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    p_bus_reqcyc  = 1'b0;
    p_bus_req     = '0;
    p_bus_reqtag  = '0;
    p_bus_respack = 1'b0;
    m_bus_reqack  = 1'b0;
    m_bus_respcyc = 1'b0;
    m_bus_resp    = '0;
    m_bus_resptag = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic rd(input logic [63:0] a, input logic [12:0] t,
                    input int dly, input int st_at, input int st_len,
                    input int bad_at, input bit hold, input int abort_at);
    logic [63:0] line;
    int ptr, cyc, rx, sent, phase, mw, acks, mreqs, first, stc;
    bit exp_hit, bad_done, aborted;
    line = a & ~64'h3F;
    ptr  = int'((a >> 3) % LW);
    exp_hit = model_access(a);
    if (exp_hit) mhits++;
    else mmiss++;
    cyc = 0; rx = 0; sent = 0; phase = 0; mw = 0;
    acks = 0; mreqs = 0; first = -1; stc = 0;
    bad_done = 1'b0; aborted = 1'b0;
    @(negedge clk);
    p_bus_reqcyc  = 1'b1;
    p_bus_req     = a;
    p_bus_reqtag  = t;
    p_bus_respack = 1'b0;
    while (rx < LW && cyc < 400) begin
      @(negedge clk);
      cyc++;
      m_bus_reqack  = 1'b0;
      m_bus_respcyc = 1'b0;
      m_bus_resp    = '0;
      m_bus_resptag = '0;
      if (!hold) p_bus_reqcyc = 1'b0;
      if (phase == 1 && sent == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (phase == 1) begin
        m_bus_respcyc = 1'b1;
        if (sent == bad_at && !bad_done) begin
          m_bus_resptag = t ^ 13'h0F0;
          m_bus_resp    = 64'hDEAD_0BAD_DEAD_0BAD;
          bad_done      = 1'b1;
        end else begin
          m_bus_resptag = t;
          m_bus_resp    = mem(line + 64'(8 * sent));
          sent++;
          if (sent == LW) phase = 2;
        end
      end
      #1;
      if (p_bus_reqack) acks++;
      if (cyc == 1) chk("reqack_c1", 64'(p_bus_reqack), 64'd1);
      if (m_bus_respcyc) chk("m_respack", 64'(m_bus_respack), 64'd1);
      if (m_bus_reqcyc) begin
        chk("m_req", m_bus_req, line);
        chk("m_reqtag", 64'(m_bus_reqtag), 64'(t));
        if (mw >= dly) begin
          m_bus_reqack = 1'b1;
          phase = 1;
          mreqs++;
        end
        mw++;
      end
      p_bus_respack = 1'b0;
      if (p_bus_respcyc) begin
        if (first < 0) first = cyc;
        chk("resp", p_bus_resp, mem(line + 64'(8 * ptr)));
        chk("resptag", 64'(p_bus_resptag), 64'(t));
        if (rx == st_at && stc < st_len) begin
          stc++;
        end else begin
          p_bus_respack = 1'b1;
          rx++;
          ptr = (ptr + 1) % LW;
        end
      end
    end
    if (aborted) begin
      p_bus_reqcyc = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_mreqcyc", 64'(m_bus_reqcyc), 64'd0);
      chk("abort_respack", 64'(m_bus_respack), 64'd0);
      chk("abort_respcyc", 64'(p_bus_respcyc), 64'd0);
      model_clear();
    end else begin
      chk("beats", 64'(rx), 64'(LW));
      @(negedge clk);
      p_bus_reqcyc  = 1'b0;
      p_bus_respack = 1'b0;
      #1;
      chk("end_respcyc", 64'(p_bus_respcyc), 64'd0);
      chk("acks", 64'(acks), 64'd1);
      chk("mreqs", 64'(mreqs), exp_hit ? 64'd0 : 64'd1);
      if (exp_hit) chk("hit_lat", 64'(first), 64'd3);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_reqack", 64'(p_bus_reqack), 64'd0);
    chk("rst_respcyc", 64'(p_bus_respcyc), 64'd0);
    chk("rst_resp", p_bus_resp, 64'd0);
    chk("rst_mreqcyc", 64'(m_bus_reqcyc), 64'd0);
    chk("rst_mreq", m_bus_req, 64'd0);
    chk("rst_mrespack", 64'(m_bus_respack), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    rd(64'h1000, 13'h011, 0, 99, 0, 99, 1'b0, -1);
    rd(64'h1018, 13'h022, 0, 99, 0, 99, 1'b1, -1);

    do_reset();
    rd(64'h0000, 13'h001, 0, 99, 0, 99, 1'b0, -1);
    rd(64'h0800, 13'h002, 1, 99, 0, 99, 1'b0, -1);
    rd(64'h1000, 13'h003, 0, 99, 0, 99, 1'b0, -1);
    rd(64'h0808, 13'h004, 0, 99, 0, 99, 1'b0, -1);
    rd(64'h0010, 13'h005, 2, 99, 0, 99, 1'b0, -1);
    rd(64'h0800, 13'h1A5, 0, 2, 5, 99, 1'b1, -1);
    rd(64'h2000, 13'h033, 10, 99, 0, 3, 1'b0, -1);

    rd(64'h4040, 13'h044, 0, 99, 0, 99, 1'b0, 3);
    rd(64'h1000, 13'h055, 0, 99, 0, 99, 1'b0, -1);
    rd(64'h1008, 13'h056, 0, 99, 0, 99, 1'b0, -1);
    rd(64'h1030, 13'h057, 0, 99, 0, 99, 1'b0, -1);
`ifdef SA_CACHE_PERF_CNT_EN
    chk("perf_hit", 64'(hit_count), 64'(mhits));
    chk("perf_miss", 64'(miss_count), 64'(mmiss));
`endif

    for (int i = 0; i < 40; i++) begin
      logic [63:0] a;
      a = (64'($urandom_range(0, 5)) << 11)
        | (64'($urandom_range(0, 2)) << 6)
        | 64'($urandom_range(0, 63));
      rd(a, 13'($urandom), $urandom_range(0, 3),
         $urandom_range(0, 9), $urandom_range(0, 3),
         $urandom_range(0, 11), 1'($urandom_range(0, 1)), -1);
    end
`ifdef SA_CACHE_PERF_CNT_EN
    chk("perf_hit_end", 64'(hit_count), 64'(mhits));
    chk("perf_miss_end", 64'(miss_count), 64'(mmiss));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
